fifth_cpu: RTL and testbench
============================

# fifth_cpu

Single-issue 16-bit Forth stack processor (J1-style instruction set) that executes one instruction per clock from a word-addressed code ROM and drives a single-port data memory bus. It sits between an asynchronous-read instruction ROM and an asynchronous-read, synchronous-write data RAM/IO decoder. Data and return stacks are internal 16-entry register files.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  reset, synchronous and active-high.
- code_addr  out  13  word address of the current instruction; equals PC register.
- instruction  in  16  instruction word at code_addr, valid combinationally in the same cycle.
- mem_address  out  16  data memory address; always equals T (top of data stack).
- mem_write_enable  out  1  write strobe; memory captures mem_data_output at mem_address on the next rising edge.
- mem_data_input  in  16  read data at mem_address, combinational, same cycle.
- mem_data_output  out  16  write data; always equals N (second of data stack).

## Operation
- State: PC[12:0], T[15:0], dsp[3:0], rsp[3:0], dstack[16]x16, rstack[16]x16. N = dstack[dsp], R = rstack[rsp].
- Decode on instruction[15:13]:
  - 1xx literal: dsp+1, dstack[dsp+1]=T, T={0,insn[14:0]}, PC+1.
  - 000 jump: PC=insn[12:0].
  - 001 conditional jump: if T==0 then PC=insn[12:0] else PC+1; always pop (T=N, dsp-1).
  - 010 call: rsp+1, rstack[rsp+1]={3'b0,PC+1}, PC=insn[12:0].
  - 011 ALU: fields insn[12] R->PC, [11:8] op, [7] T->N, [6] T->R, [5] N->[T], [4] reserved (ignored), [3:2] rstack delta, [1:0] dstack delta.
- Deltas are 2-bit signed: 00 = 0, 01 = +1, 10 = -2, 11 = -1. Pointers wrap modulo 16; no overflow or underflow detection.
- ALU instruction effects: T = result; dsp += dd; rsp += rd; if T->N then dstack[new dsp] = old T; if T->R then rstack[new rsp] = old T; PC = R->PC ? R[12:0] (old R) : PC+1; mem_write_enable = N->[T].
- ALU ops (old T, N, R): 0 T; 1 N; 2 T+N; 3 T&N; 4 T|N; 5 T^N; 6 ~T; 7 N==T; 8 N<T signed; 9 N>>T[3:0] logical; 10 T-1; 11 R; 12 mem_data_input; 13 N<<T[3:0]; 14 N<T unsigned; 15 see Configuration.
- Comparison results: true = 16'hFFFF, false = 16'h0000. All arithmetic is 16-bit modulo.
- PC+1 wraps 8191 -> 0.

## Timing
- Zero-latency fetch: instruction is executed in the cycle code_addr presents its address. Every instruction completes in 1 cycle; there are no stalls.
- Memory read (op 12) uses mem_data_input in the same cycle that mem_address = T.
- Memory write: mem_write_enable is combinational from the ALU instruction; the write takes effect at the closing rising edge.
- Reset (reset=1 at a rising edge): PC=0, T=0, dsp=0, rsp=0, all stack entries cleared to 0.
- While reset is high: code_addr=0, mem_address=0, mem_data_output=0, mem_write_enable=0 (forced), and no state is modified other than by reset.
- Reset asserted mid-program takes priority over the instruction in flight. Execution resumes at address 0 on the first edge after reset falls.

## Configuration
- FIFTH_MUL_EN defined: ALU op 15 = low 16 bits of N*T (unsigned).
- FIFTH_MUL_EN undefined: ALU op 15 = T (behaves like op 0), and no multiplier is synthesized.

## Test plan
- Reset then literal 16'h8005 at addr 0: after 1 cycle T=5, dsp=1, code_addr=1.
- Program 8003, 8004, 6203 (T+N, dd=-1): T=7, dsp back to 1 after 3 cycles.
- Program 8000, 2005 (conditional jump on zero): code_addr=5 next, and the literal is popped. The same program with literal 8001 goes to code_addr=2.
- Call 4010 at addr 2: code_addr=16, R=3. A return instruction (6 with R->PC, rd=-1: 16'h700C) at addr 16 brings code_addr back to 3.
- Literal 0x1234, literal 0x0040, then 6023 (N->[T], dd=-1): mem_write_enable=1, mem_address=0x40, mem_data_output=0x1234 that cycle. A following read (0x0040, then 6C00) yields T=0x1234.
- Assert reset during a write instruction: mem_write_enable=0, and on the next edge PC=0, T=0.

Source files
------------

// File: rtl/fifth_cpu.sv
// fifth_cpu: single-issue 16-bit Forth stack processor (J1-style ISA).
// One instruction per clock from an async-read code ROM, single-port data bus.
// Optional feature macro: FIFTH_MUL_EN (ALU op 15 = low 16 bits of N*T).
module fifth_cpu (
  input  logic        clk,
  input  logic        reset,
  output logic [12:0] code_addr,
  input  logic [15:0] instruction,
  output logic [15:0] mem_address,
  output logic        mem_write_enable,
  input  logic [15:0] mem_data_input,
  output logic [15:0] mem_data_output
);

  logic [12:0] pc;
  logic [15:0] t;
  logic [3:0]  dsp;
  logic [3:0]  rsp;
  logic [15:0] dstack [16];
  logic [15:0] rstack [16];
  logic [15:0] n;
  logic [15:0] r;

  logic [12:0] pc_next;
  logic [15:0] t_next;
  logic [3:0]  dsp_next;
  logic [3:0]  rsp_next;
  logic        d_we;
  logic [3:0]  d_wa;
  logic [15:0] d_wd;
  logic        r_we;
  logic [3:0]  r_wa;
  logic [15:0] r_wd;
  logic        mem_we;

  assign n = dstack[dsp];
  assign r = rstack[rsp];

  // 2-bit signed stack delta sign-extended to pointer width; add wraps mod 16
  function automatic logic [3:0] delta(input logic [1:0] d);
    return {{2{d[1]}}, d};
  endfunction

  function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] tv,
                                      input logic [15:0] nv, input logic [15:0] rv,
                                      input logic [15:0] md);
    logic signed [15:0] ts;
    logic signed [15:0] ns;
    logic [15:0]        res;
    ts = tv;
    ns = nv;
    case (op)
      4'd0:  res = tv;
      4'd1:  res = nv;
      4'd2:  res = tv + nv;
      4'd3:  res = tv & nv;
      4'd4:  res = tv | nv;
      4'd5:  res = tv ^ nv;
      4'd6:  res = ~tv;
      4'd7:  res = (nv == tv) ? 16'hFFFF : 16'h0000;
      4'd8:  res = (ns < ts) ? 16'hFFFF : 16'h0000;
      4'd9:  res = nv >> tv[3:0];
      4'd10: res = tv - 16'd1;
      4'd11: res = rv;
      4'd12: res = md;
      4'd13: res = nv << tv[3:0];
      4'd14: res = (nv < tv) ? 16'hFFFF : 16'h0000;
`ifdef FIFTH_MUL_EN
      default: res = nv * tv;
`else
      default: res = tv;
`endif
    endcase
    return res;
  endfunction

  // Decode the current instruction into next-state values and stack writes
  always_comb begin
    pc_next  = pc + 13'd1;
    t_next   = t;
    dsp_next = dsp;
    rsp_next = rsp;
    d_we     = 1'b0;
    d_wa     = dsp;
    d_wd     = t;
    r_we     = 1'b0;
    r_wa     = rsp;
    r_wd     = t;
    mem_we   = 1'b0;
    if (instruction[15]) begin
      dsp_next = dsp + 4'd1;
      d_we     = 1'b1;
      d_wa     = dsp + 4'd1;
      t_next   = {1'b0, instruction[14:0]};
    end else begin
      case (instruction[14:13])
        2'b00: pc_next = instruction[12:0];
        2'b01: begin
          if (t == 16'h0000) pc_next = instruction[12:0];
          t_next   = n;
          dsp_next = dsp - 4'd1;
        end
        2'b10: begin
          rsp_next = rsp + 4'd1;
          r_we     = 1'b1;
          r_wa     = rsp + 4'd1;
          r_wd     = {3'b000, pc + 13'd1};
          pc_next  = instruction[12:0];
        end
        default: begin
          t_next   = alu(instruction[11:8], t, n, r, mem_data_input);
          dsp_next = dsp + delta(instruction[1:0]);
          rsp_next = rsp + delta(instruction[3:2]);
          d_we     = instruction[7];
          d_wa     = dsp + delta(instruction[1:0]);
          r_we     = instruction[6];
          r_wa     = rsp + delta(instruction[3:2]);
          if (instruction[12]) pc_next = r[12:0];
          mem_we   = instruction[5];
        end
      endcase
    end
  end

  // Architectural state update; reset overrides the instruction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= '0;
      t   <= '0;
      dsp <= '0;
      rsp <= '0;
      for (int i = 0; i < 16; i++) begin
        dstack[i] <= '0;
        rstack[i] <= '0;
      end
    end else begin
      pc  <= pc_next;
      t   <= t_next;
      dsp <= dsp_next;
      rsp <= rsp_next;
      if (d_we) dstack[d_wa] <= d_wd;
      if (r_we) rstack[r_wa] <= r_wd;
    end
  end

  assign code_addr        = reset ? 13'd0 : pc;
  assign mem_address      = reset ? 16'd0 : t;
  assign mem_data_output  = reset ? 16'd0 : n;
  assign mem_write_enable = mem_we & ~reset;

endmodule

// File: tb/tb_fifth_cpu.sv
// Directed testbench for fifth_cpu with a behavioural code ROM and data RAM.
module tb_fifth_cpu;

  logic        clk;
  logic        reset;
  logic [12:0] code_addr;
  logic [15:0] instruction;
  logic [15:0] mem_address;
  logic        mem_write_enable;
  logic [15:0] mem_data_input;
  logic [15:0] mem_data_output;

  logic [15:0] rom [0:8191];
  logic [15:0] ram [0:255];
  logic        ram_clr;

  int passed;
  int failed;
  int total;

  fifth_cpu dut (
    .clk              (clk),
    .reset            (reset),
    .code_addr        (code_addr),
    .instruction      (instruction),
    .mem_address      (mem_address),
    .mem_write_enable (mem_write_enable),
    .mem_data_input   (mem_data_input),
    .mem_data_output  (mem_data_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instruction    = rom[code_addr];
  assign mem_data_input = ram[mem_address[7:0]];

  // Data RAM: synchronous write, clear preloads a known value at address 5
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= (i == 5) ? 16'hBEEF : 16'h0000;
    end else if (mem_write_enable) begin
      ram[mem_address[7:0]] <= mem_data_output;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 8192; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    ram_clr = 1'b1;
    tick();
    reset   = 1'b0;
    ram_clr = 1'b0;
  endtask

  task automatic run4(input logic [15:0] i0, input logic [15:0] i1,
                      input logic [15:0] i2, input logic [15:0] i3);
    clear_rom();
    rom[0] = i0;
    rom[1] = i1;
    rom[2] = i2;
    rom[3] = i3;
    do_reset();
    repeat (4) tick();
  endtask

  initial begin
    passed  = 0;
    failed  = 0;
    total   = 0;
    reset   = 1'b1;
    ram_clr = 1'b0;

    // Reset state and a single literal
    clear_rom();
    rom[0] = 16'h8005;
    do_reset();
    chk("rst_code_addr", {3'b0, code_addr}, 16'h0000);
    chk("rst_T", mem_address, 16'h0000);
    chk("rst_N", mem_data_output, 16'h0000);
    chk("rst_we", {15'b0, mem_write_enable}, 16'h0000);
    chk("rst_dsp", {12'b0, dut.dsp}, 16'h0000);
    tick();
    chk("lit_T", mem_address, 16'h0005);
    chk("lit_dsp", {12'b0, dut.dsp}, 16'h0001);
    chk("lit_pc", {3'b0, code_addr}, 16'h0001);

    // 3 + 4 with dd=-1
    clear_rom();
    rom[0] = 16'h8003; rom[1] = 16'h8004; rom[2] = 16'h6203;
    do_reset();
    repeat (3) tick();
    chk("add_T", mem_address, 16'h0007);
    chk("add_dsp", {12'b0, dut.dsp}, 16'h0001);
    chk("add_N", mem_data_output, 16'h0000);
    chk("add_pc", {3'b0, code_addr}, 16'h0003);

    // Conditional jump taken on zero, with pop
    clear_rom();
    rom[0] = 16'h8000; rom[1] = 16'h2005;
    do_reset();
    repeat (2) tick();
    chk("cj_taken_pc", {3'b0, code_addr}, 16'h0005);
    chk("cj_taken_dsp", {12'b0, dut.dsp}, 16'h0000);
    // Not taken on nonzero
    rom[0] = 16'h8001;
    do_reset();
    repeat (2) tick();
    chk("cj_fall_pc", {3'b0, code_addr}, 16'h0002);
    chk("cj_fall_T", mem_address, 16'h0000);
    chk("cj_fall_dsp", {12'b0, dut.dsp}, 16'h0000);

    // Call and return
    clear_rom();
    rom[0] = 16'h8007; rom[1] = 16'h8008; rom[2] = 16'h4010; rom[16] = 16'h700C;
    do_reset();
    repeat (3) tick();
    chk("call_pc", {3'b0, code_addr}, 16'h0010);
    chk("call_R", dut.r, 16'h0003);
    chk("call_rsp", {12'b0, dut.rsp}, 16'h0001);
    tick();
    chk("ret_pc", {3'b0, code_addr}, 16'h0003);
    chk("ret_rsp", {12'b0, dut.rsp}, 16'h0000);
    chk("ret_T", mem_address, 16'h0008);

    // Memory store then load
    clear_rom();
    rom[0] = 16'h9234; rom[1] = 16'h8040; rom[2] = 16'h6023;
    rom[3] = 16'h8040; rom[4] = 16'h6C00;
    do_reset();
    repeat (2) tick();
    chk("st_we", {15'b0, mem_write_enable}, 16'h0001);
    chk("st_addr", mem_address, 16'h0040);
    chk("st_data", mem_data_output, 16'h1234);
    tick();
    chk("st_ram", ram[8'h40], 16'h1234);
    chk("st_we_off", {15'b0, mem_write_enable}, 16'h0000);
    repeat (2) tick();
    chk("ld_T", mem_address, 16'h1234);

    // Reset asserted during a write instruction
    clear_rom();
    rom[0] = 16'h9234; rom[1] = 16'h8040; rom[2] = 16'h6023;
    do_reset();
    repeat (2) tick();
    chk("rw_pre_we", {15'b0, mem_write_enable}, 16'h0001);
    reset = 1'b1;
    #1;
    chk("rw_we", {15'b0, mem_write_enable}, 16'h0000);
    chk("rw_code_addr", {3'b0, code_addr}, 16'h0000);
    chk("rw_addr", mem_address, 16'h0000);
    chk("rw_data", mem_data_output, 16'h0000);
    tick();
    chk("rw_pc", {3'b0, dut.pc}, 16'h0000);
    chk("rw_T", dut.t, 16'h0000);
    chk("rw_dsp", {12'b0, dut.dsp}, 16'h0000);
    chk("rw_ram", ram[8'h40], 16'h0000);
    reset = 1'b0;
    tick();
    chk("rw_resume", mem_address, 16'h1234);

    // ALU op sweep with N=0x1234, T=0x0005, dd=0
    run4(16'h8000, 16'h9234, 16'h8005, 16'h6000); chk("op0", mem_address, 16'h0005);
    run4(16'h8000, 16'h9234, 16'h8005, 16'h6100); chk("op1", mem_address, 16'h1234);
    run4(16'h8000, 16'h9234, 16'h8005, 16'h6200); chk("op2", mem_address, 16'h1239);
    run4(16'h8000, 16'h9234, 16'h8005, 16'h6300); chk("op3", mem_address, 16'h0004);
    run4(16'h8000, 16'h9234, 16'h8005, 16'h6400); chk("op4", mem_address, 16'h1235);
    run4(16'h8000, 16'h9234, 16'h8005, 16'h6500); chk("op5", mem_address, 16'h1231);
    run4(16'h8000, 16'h9234, 16'h8005, 16'h6600); chk("op6", mem_address, 16'hFFFA);
    run4(16'h8000, 16'h9234, 16'h8005, 16'h6700); chk("op7_ne", mem_address, 16'h0000);
    run4(16'h8000, 16'h8005, 16'h8005, 16'h6700); chk("op7_eq", mem_address, 16'hFFFF);
    run4(16'h8000, 16'h9234, 16'h8005, 16'h6900); chk("op9", mem_address, 16'h0091);
    run4(16'h8000, 16'h9234, 16'h8014, 16'h6900); chk("op9_t30", mem_address, 16'h0123);
    run4(16'h8000, 16'h9234, 16'h8005, 16'h6A00); chk("op10", mem_address, 16'h0004);
    run4(16'h8000, 16'h9234, 16'h8005, 16'h6B00); chk("op11", mem_address, 16'h0000);
    run4(16'h8000, 16'h9234, 16'h8005, 16'h6C00); chk("op12", mem_address, 16'hBEEF);
    run4(16'h8000, 16'h9234, 16'h8005, 16'h6D00); chk("op13", mem_address, 16'h4680);
    run4(16'h8000, 16'h9234, 16'h8005, 16'h6E00); chk("op14_f", mem_address, 16'h0000);
    run4(16'h8000, 16'h8003, 16'h8005, 16'h6E00); chk("op14_t", mem_address, 16'hFFFF);
    run4(16'h8000, 16'h8003, 16'h8005, 16'h6800); chk("op8_t", mem_address, 16'hFFFF);
`ifdef FIFTH_MUL_EN
    run4(16'h8000, 16'h9234, 16'h8005, 16'h6F00); chk("op15", mem_address, 16'h5B04);
`else
    run4(16'h8000, 16'h9234, 16'h8005, 16'h6F00); chk("op15", mem_address, 16'h0005);
`endif

    // Signed vs unsigned compare with N = 0xFFFA, T = 3
    run4(16'h8005, 16'h6600, 16'h8003, 16'h6800); chk("op8_neg", mem_address, 16'hFFFF);
    run4(16'h8005, 16'h6600, 16'h8003, 16'h6E00); chk("op14_neg", mem_address, 16'h0000);

    // DUP (T->N, dd=+1), T->R push then R fetch, dd=-2
    run4(16'h8000, 16'h9234, 16'h8005, 16'h6081);
    chk("dup_N", mem_data_output, 16'h0005);
    chk("dup_dsp", {12'b0, dut.dsp}, 16'h0004);
    run4(16'h8000, 16'h8007, 16'h6044, 16'h6B00);
    chk("tor_T", mem_address, 16'h0007);
    chk("tor_rsp", {12'b0, dut.rsp}, 16'h0001);
    run4(16'h8001, 16'h8002, 16'h8003, 16'h6102);
    chk("dd2_T", mem_address, 16'h0002);
    chk("dd2_dsp", {12'b0, dut.dsp}, 16'h0001);

    // PC wraps from 8191 to 0
    clear_rom();
    rom[0] = 16'h1FFF; rom[8191] = 16'h8009;
    do_reset();
    tick();
    chk("wrap_top", {3'b0, code_addr}, 16'h1FFF);
    tick();
    chk("wrap_pc", {3'b0, code_addr}, 16'h0000);
    chk("wrap_T", mem_address, 16'h0009);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
